// File: rtl/count_checker.sv
// Monitors a free-running count stream and checks that each sample is the
// previous sample + 1 (mod 2^WIDTH). Reports lock status, per-sample error pulses and a saturating error total.
module count_checker #(
  parameter int WIDTH         = 33,
  parameter int ERR_CNT_W     = 16,
  parameter int LOCK_THRESH   = 4,
  parameter int UNLOCK_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected
);

  localparam int RUN_W  = (LOCK_THRESH   < 1) ? 1 : $clog2(LOCK_THRESH + 1);
  localparam int MISS_W = (UNLOCK_THRESH < 1) ? 1 : $clog2(UNLOCK_THRESH + 1);
  localparam logic [RUN_W-1:0]     LOCK_VAL = RUN_W'(LOCK_THRESH);
  localparam logic [MISS_W-1:0]    MISS_VAL = MISS_W'(UNLOCK_THRESH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_SLIP    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [RUN_W-1:0]       r_run;
  logic [RUN_W-1:0]       w_run_nxt;
  logic [RUN_W-1:0]       w_run_inc;
  logic [MISS_W-1:0]      r_miss;
  logic [MISS_W-1:0]      w_miss_nxt;
  logic [MISS_W-1:0]      w_miss_inc;
  logic [WIDTH-1:0]       r_expected;
  logic [WIDTH-1:0]       w_exp_nxt;
  logic [WIDTH-1:0]       w_nxt;
  logic [WIDTH-1:0]       w_flywheel;
  logic                   w_match;
  logic                   w_err_hit;
  logic                   w_locked_nxt;
  logic                   r_locked;
  logic                   r_err_pulse;
  logic [ERR_CNT_W-1:0]   r_err_count;

  assign w_nxt      = count_in + 1'b1;
  assign w_flywheel = r_expected + 1'b1;
  assign w_match    = (count_in == r_expected);
  assign w_run_inc  = r_run + 1'b1;
  assign w_miss_inc = r_miss + 1'b1;

  // Next-state, run/miss counters and expected-value update for one sample
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_miss_nxt  = r_miss;
    w_exp_nxt   = r_expected;
    w_err_hit   = 1'b0;
    if (en) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ACQUIRE;
          w_exp_nxt   = w_nxt;
          w_run_nxt   = '0;
        end
        ST_ACQUIRE: begin
          w_exp_nxt = w_nxt;
          if (w_match) begin
            if (w_run_inc == LOCK_VAL) begin
              w_state_nxt = ST_LOCKED;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_run_nxt = w_run_inc;
            end
          end else begin
            w_run_nxt = '0;
          end
        end
        ST_LOCKED, ST_SLIP: begin
          if (w_match) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = '0;
            w_exp_nxt   = w_nxt;
          end else begin
            w_err_hit = 1'b1;
            // LOCKED has miss=0, so the threshold test also covers UNLOCK_THRESH==1
            if (w_miss_inc >= MISS_VAL) begin
              w_state_nxt = ST_ACQUIRE;
              w_exp_nxt   = w_nxt;
              w_run_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_state_nxt = ST_SLIP;
              w_miss_nxt  = w_miss_inc;
              w_exp_nxt   = w_flywheel;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = '0;
          w_miss_nxt  = '0;
          w_exp_nxt   = '0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  assign w_locked_nxt = (w_state_nxt == ST_LOCKED) || (w_state_nxt == ST_SLIP);

  // State, statistics and registered outputs; clear beats a simultaneous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_miss      <= '0;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_run       <= '0;
      r_miss      <= '0;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_run       <= w_run_nxt;
      r_miss      <= w_miss_nxt;
      r_expected  <= w_exp_nxt;
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_err_hit;
      if (w_err_hit && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + 1'b1;
      end else begin
        r_err_count <= r_err_count;
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule

// File: tb/tb_count_checker.sv
// Directed + randomized bench for count_checker; a behavioural model tracks
// lock/miss/expected with plain arithmetic and checks two instances (16-bit and 2-bit error counters).
module tb_count_checker;

  localparam longint unsigned MOD = 64'h2_0000_0000;
  localparam int LT = 4;
  localparam int UT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [32:0] count_in = 33'd0;

  logic        locked, err_pulse, locked_s, err_pulse_s;
  logic [15:0] err_count;
  logic [1:0]  err_count_s;
  logic [32:0] expected, expected_s;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;

  // behavioural model
  bit              m_seeded, m_locked, m_pulse;
  int              m_run, m_miss, m_total;
  longint unsigned m_exp;

  count_checker #(.WIDTH(33), .ERR_CNT_W(16), .LOCK_THRESH(LT), .UNLOCK_THRESH(UT)) dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected));

  count_checker #(.WIDTH(33), .ERR_CNT_W(2), .LOCK_THRESH(LT), .UNLOCK_THRESH(UT)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .clear(clear),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .expected(expected_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_seeded = 0; m_locked = 0; m_pulse = 0;
    m_run = 0; m_miss = 0; m_total = 0; m_exp = 0;
  endfunction

  function automatic void model_step(input bit e, input bit c, input longint unsigned v);
    longint unsigned nxt;
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else if (e) begin
      nxt = (v + 1) % MOD;
      if (!m_seeded) begin
        m_seeded = 1; m_run = 0; m_exp = nxt;
      end else if (!m_locked) begin
        m_run = (v == m_exp) ? m_run + 1 : 0;
        m_exp = nxt;
        if (m_run == LT) begin
          m_locked = 1; m_miss = 0; m_run = 0;
        end
      end else if (v == m_exp) begin
        m_miss = 0; m_exp = nxt;
      end else begin
        m_pulse = 1; m_total++; m_miss++;
        if (m_miss >= UT) begin
          m_locked = 0; m_run = 0; m_miss = 0; m_exp = nxt;
        end else begin
          m_exp = (m_exp + 1) % MOD;
        end
      end
    end
  endfunction

  function automatic longint unsigned sat(input int total, input int max);
    return (total > max) ? longint'(max) : longint'(total);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".locked"},    64'(locked),      64'(m_locked));
    check({tag, ".err_pulse"}, 64'(err_pulse),   64'(m_pulse));
    check({tag, ".err_count"}, 64'(err_count),   sat(m_total, 65535));
    check({tag, ".expected"},  64'(expected),    m_exp);
    check({tag, ".sat_count"}, 64'(err_count_s), sat(m_total, 3));
    check({tag, ".sat_pulse"}, 64'(err_pulse_s), 64'(m_pulse));
  endtask

  task automatic step(input string tag, input logic e, input logic c, input logic [32:0] v);
    en = e; clear = c; count_in = v;
    @(posedge clk);
    model_step(e, c, longint'(v));
    #1;
    check_all(tag);
  endtask

  initial begin
    int pulses;
    int r;
    logic [32:0] v;
    model_reset();

    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // lock and track
    for (int i = 0; i <= 5; i++) step("lock", 1'b1, 1'b0, 33'(i));
    check("lock.locked_const", 64'(locked), 64'd1);
    check("lock.expected_const", 64'(expected), 64'd6);

    // wrap-around
    step("wrap_clr", 1'b1, 1'b1, 33'd0);
    for (int i = 0; i < 6; i++) step("wrap", 1'b1, 1'b0, 33'h1_FFFF_FFFA + 33'(i));
    step("wrap0", 1'b1, 1'b0, 33'd0);
    step("wrap1", 1'b1, 1'b0, 33'd1);
    check("wrap.expected_const", 64'(expected), 64'd2);
    check("wrap.err_const", 64'(err_count), 64'd0);

    // single glitch
    step("glitch_clr", 1'b1, 1'b1, 33'd0);
    for (int i = 6; i <= 11; i++) step("glitch", 1'b1, 1'b0, 33'(i));
    step("glitch99", 1'b1, 1'b0, 33'd99);
    check("glitch.pulse_const", 64'(err_pulse), 64'd1);
    step("glitch13", 1'b1, 1'b0, 33'd13);
    check("glitch.locked_const", 64'(locked), 64'd1);
    check("glitch.err_const", 64'(err_count), 64'd1);

    // loss of lock and re-lock
    step("loss_clr", 1'b1, 1'b1, 33'd0);
    for (int i = 16; i <= 21; i++) step("loss", 1'b1, 1'b0, 33'(i));
    step("loss50", 1'b1, 1'b0, 33'd50);
    step("loss60", 1'b1, 1'b0, 33'd60);
    check("loss.unlocked_const", 64'(locked), 64'd0);
    for (int i = 61; i <= 64; i++) step("relock", 1'b1, 1'b0, 33'(i));
    check("relock.locked_const", 64'(locked), 64'd1);
    check("relock.err_const", 64'(err_count), 64'd2);

    // saturation: alternate mismatch / recovering match to stay locked
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step("sat_bad", 1'b1, 1'b0, 33'((m_exp + 1000) % MOD));
      pulses += int'(err_pulse_s);
      step("sat_good", 1'b1, 1'b0, 33'(m_exp));
    end
    check("sat.pulses", 64'(pulses), 64'd5);
    check("sat.count_const", 64'(err_count_s), 64'd3);

    // clear together with en: sample discarded, back to IDLE
    step("clear_en", 1'b1, 1'b1, 33'd500);
    check("clear.err_const", 64'(err_count), 64'd0);
    step("idle_seed", 1'b1, 1'b0, 33'd100);
    check("idle.expected_const", 64'(expected), 64'd101);

    // async reset mid-stream while locked
    for (int i = 101; i <= 105; i++) step("pre_rst", 1'b1, 1'b0, 33'(i));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst.locked", 64'(locked), 64'd0);
    check("arst.err_count", 64'(err_count), 64'd0);
    check("arst.expected", 64'(expected), 64'd0);
    #1 rst = 1'b0;

    // en gaps do not cause errors
    for (int i = 0; i <= 7; i++) step("gap", 1'b1, 1'b0, 33'(i));
    repeat (3) step("gap_idle", 1'b0, 1'b0, 33'd12345);
    step("gap8", 1'b1, 1'b0, 33'd8);
    check("gap.locked_const", 64'(locked), 64'd1);
    check("gap.err_const", 64'(err_count), 64'd0);

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      v = 33'(m_exp);
      else if (r < 80) v = 33'((m_exp + MOD - 1) % MOD);
      else if (r < 90) v = 33'(MOD - 1 - longint'($urandom_range(0, 3)));
      else             v = {1'($urandom_range(0, 1)), 32'($urandom)};
      step("rand", ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0), v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/count_checker.md
Name: count_checker

Overview:
- Consumes the free-running count stream produced by the counter block.
- Checks that each sampled value is exactly the previous value + 1, modulo 2^WIDTH.
- Reports lock status, per-sample error pulses and a saturating error total.
- Sits beside the counter as its in-fabric monitor, replacing manual waveform inspection.

Parameters:
- WIDTH, 33, bit width of the checked count (matches counter output).
- ERR_CNT_W, 16, width of the saturating error counter.
- LOCK_THRESH, 4, consecutive correct increments needed to declare lock (>=1).
- UNLOCK_THRESH, 2, consecutive mismatches that drop lock (>=1).

Ports:
- clk  input  1  rising-edge clock, shared with the counter.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  sample strobe; count_in is evaluated only when en=1.
- count_in  input  WIDTH  count value under check.
- clear  input  1  synchronous clear of statistics and state.
- locked  output  1  high while in LOCKED or SLIP.
- err_pulse  output  1  one-cycle pulse per mismatching sample while locked.
- err_count  output  ERR_CNT_W  total mismatches, saturating at all-ones.
- expected  output  WIDTH  value the next sample must equal.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, locked=0, err_pulse=0, err_count=0, expected=0, internal run counters=0.
- All outputs are registered. err_pulse, locked and expected update on the clk edge that samples en=1, so they are visible one cycle after the sample is presented.
- Define nxt = count_in + 1, truncated to WIDTH. All-ones followed by 0 is a legal match; no carry-out is kept.
- States and transitions (evaluated only when en=1; with en=0 all state holds and err_pulse=0):
  - IDLE: first sample sets expected<=nxt and run=0, then goes to ACQUIRE.
  - ACQUIRE:
    - Match (count_in==expected): run++. If run reaches LOCK_THRESH, go to LOCKED.
    - Mismatch: run<=0, stay in ACQUIRE.
    - In both cases expected<=nxt. No errors are counted.
  - LOCKED:
    - Match: expected<=nxt.
    - Mismatch: err_pulse=1, err_count++, miss=1, expected<=expected+1 (flywheel, does not reseed), go to SLIP. If UNLOCK_THRESH==1, go directly to ACQUIRE with expected<=nxt and run=0.
  - SLIP:
    - Match: miss<=0, expected<=nxt, return to LOCKED.
    - Mismatch: err_pulse=1, err_count++, miss++. If miss reaches UNLOCK_THRESH, go to ACQUIRE with expected<=nxt and run=0; otherwise expected<=expected+1.
- err_count saturates at 2^ERR_CNT_W-1 and never wraps. err_pulse still fires while saturated.
- clear=1: state<=IDLE, err_count<=0, run/miss<=0, locked<=0, err_pulse<=0, expected<=0. clear has priority over a simultaneous en, and that sample is discarded.
- An LOCK_THRESH crossing and a mismatch cannot coincide, because ACQUIRE ignores errors.
- rst asserted mid-operation forces reset values immediately, independent of clk.
- Repeated identical samples (counter stalled, e.g. held in reset) are mismatches.

Test Plan:
- Lock and track: rst 2 cycles, then en=1 with count_in 0,1,2,3,4,5 -> locked=1 after the sample 4 edge, err_count=0, expected=6.
- Wrap-around: after lock, feed 0x1_FFFF_FFFE, 0x1_FFFF_FFFF, 0x0_0000_0000, 1 -> no err_pulse, locked stays 1, expected=2.
- Single glitch: locked stream 10,11,99,13 -> one err_pulse on the 99 sample, SLIP then back to LOCKED on 13, err_count=1, locked never drops.
- Loss of lock: locked stream 20,21,50,60,61,62,63,64 -> err_pulse on 50 and 60, locked=0 after 60, err_count=2, re-lock after 64 (4 matches).
- Saturation and clear: ERR_CNT_W=2, force 5 mismatches while locked -> err_count stays 3 with 5 err_pulses. Then clear=1 together with en=1 -> err_count=0, state IDLE, that sample ignored.
- Async reset mid-stream: assert rst between clk edges while locked -> locked, err_count and expected go to 0 before the next edge. en gaps (en=0 for 3 cycles between 7 and 8) -> no error.
